// File: rtl/cpu_dbg_pkg.sv
// ============================================================================
// Module : cpu_dbg_pkg
// Brief  : Shared types and helpers for the CPU bring-up run controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        RUN   = 3'd2,
        DUMP  = 3'd3,
        DONE  = 3'd4
    } run_state_t;

    localparam int WORD_BYTES = 4;
    localparam int CHK_MAX_W  = 64;

    // Checksum combine step; callers truncate the result to their word width.
    function automatic logic [CHK_MAX_W-1:0] chk_add(
        input logic [CHK_MAX_W-1:0] i_acc,
        input logic [CHK_MAX_W-1:0] i_word
    );
        return i_acc + i_word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_window_scanner.sv
// ============================================================================
// Module : mem_window_scanner
// Brief  : Strobes a data-memory window word by word and sums the returned data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_window_scanner
    import cpu_dbg_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] DUMP_BASE  = '0,
    parameter int                DUMP_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_go,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_busy,
    output logic              o_last
);

    localparam int             IDX_W      = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DUMP_WORDS - 1);

    logic              r_rd_en;
    logic              r_vld;
    logic [ADDR_W-1:0] r_addr;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en <= 1'b0;
            r_vld   <= 1'b0;
            r_addr  <= '0;
            r_idx   <= '0;
            r_sum   <= '0;
        end else begin
            // Read data returns one cycle after its strobe.
            r_vld <= r_rd_en;
            if (i_clr) begin
                r_sum <= '0;
            end else if (r_vld) begin
                r_sum <= DATA_W'(chk_add(CHK_MAX_W'(r_sum), CHK_MAX_W'(i_rdata)));
            end

            if (i_go) begin
                r_rd_en <= 1'b1;
                r_addr  <= DUMP_BASE;
                r_idx   <= '0;
            end else if (r_rd_en) begin
                if (r_idx == c_last_idx) begin
                    r_rd_en <= 1'b0;
                end else begin
                    r_addr <= r_addr + ADDR_W'(WORD_BYTES);
                    r_idx  <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_rd_en = r_rd_en;
    assign o_addr  = r_addr;
    assign o_sum   = r_sum;
    assign o_busy  = r_rd_en | r_vld;
    assign o_last  = r_vld & ~r_rd_en;

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// Module : cpu_run_ctrl
// Brief  : Sequences CPU reset, gates its run until halt/timeout, then checksums memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                RESET_CYCLES = 4,
    parameter int                HALT_STABLE  = 8,
    parameter longint unsigned   MAX_CYCLES   = 500,
    parameter logic [ADDR_W-1:0] DUMP_BASE    = '0,
    parameter int                DUMP_WORDS   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_cpu_rst_n,
    output logic              o_cpu_run,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [31:0]       o_cycle_count,
    output logic [DATA_W-1:0] o_checksum,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout
);

    generate
        if (RESET_CYCLES < 1 || HALT_STABLE < 2 || MAX_CYCLES < 1 ||
            MAX_CYCLES >= 64'h1_0000_0000 || DUMP_WORDS < 1 || DATA_W > CHK_MAX_W) begin : g_param_check
            $error("cpu_run_ctrl: illegal parameter combination");
        end
    endgenerate

    localparam int               RST_W      = $clog2(RESET_CYCLES + 1);
    localparam int               STB_W      = $clog2(HALT_STABLE + 1);
    localparam logic [RST_W-1:0] c_rst_last = RST_W'(RESET_CYCLES - 1);
    localparam logic [STB_W-1:0] c_halt_at  = STB_W'(HALT_STABLE - 1);
    localparam logic [31:0]      c_cyc_last = 32'(MAX_CYCLES - 1);

    run_state_t        r_state;
    run_state_t        w_state_next;
    logic [RST_W-1:0]  r_rst_cnt;
    logic [STB_W-1:0]  r_stab;
    logic [STB_W-1:0]  w_stab_next;
    logic [ADDR_W-1:0] r_prev_pc;
    logic [31:0]       r_cycle_count;
    logic              r_timeout;
    logic              w_accept;
    logic              w_go;
    logic              w_halt;
    logic              w_tmo;
    logic              w_scan_busy;
    logic              w_scan_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_go         = 1'b0;
        w_halt       = 1'b0;
        w_tmo        = 1'b0;
        w_stab_next  = '0;
        if (i_pc == r_prev_pc) begin
            w_stab_next = (r_stab == c_halt_at) ? r_stab : r_stab + 1'b1;
        end

        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = RESET;
                end
            end
            RESET: begin
                if (r_rst_cnt == c_rst_last) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_halt = (w_stab_next == c_halt_at);
                w_tmo  = (r_cycle_count == c_cyc_last);
                if ((w_halt || w_tmo) && !w_scan_busy) begin
                    w_go         = 1'b1;
                    w_state_next = DUMP;
                end
            end
            DUMP: begin
                if (w_scan_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        o_cpu_run   = (r_state == RUN);
        o_cpu_rst_n = (r_state == RUN) || (r_state == DUMP) || (r_state == DONE);
        o_busy      = (r_state == RESET) || (r_state == RUN) || (r_state == DUMP);
        o_done      = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_cnt     <= '0;
            r_stab        <= '0;
            r_prev_pc     <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_prev_pc <= i_pc;
            if (w_accept) begin
                r_rst_cnt     <= '0;
                r_stab        <= '0;
                r_cycle_count <= '0;
                r_timeout     <= 1'b0;
            end else begin
                if (r_state == RESET) begin
                    r_rst_cnt <= r_rst_cnt + 1'b1;
                end
                // Stability only counts while the CPU is running; a held PC in reset is not a halt.
                if (r_state == RUN) begin
                    r_stab <= w_stab_next;
                    if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + 32'd1;
                    end
                    if (w_go) begin
                        r_timeout <= w_tmo & ~w_halt;
                    end
                end
            end
        end
    end

    mem_window_scanner #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DUMP_BASE  (DUMP_BASE),
        .DUMP_WORDS (DUMP_WORDS)
    ) u_scanner (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_accept),
        .i_go    (w_go),
        .i_rdata (i_mem_rdata),
        .o_rd_en (o_mem_rd_en),
        .o_addr  (o_mem_addr),
        .o_sum   (o_checksum),
        .o_busy  (w_scan_busy),
        .o_last  (w_scan_last)
    );

    assign o_cycle_count = r_cycle_count;
    assign o_timeout     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// Module : tb_cpu_run_ctrl
// Brief  : Directed self-checking bench for cpu_run_ctrl with default parameters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc;
    logic        cpu_rst_n, cpu_run, mem_rd_en;
    logic [31:0] mem_addr, mem_rdata, cycle_count, checksum;
    logic        busy, done, timeout;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [16];
    int          mode = 0;
    int          run_idx = 0;
    int          pcyc = 0;
    int          t_acc = 0;
    logic        log_clr = 1'b0;
    int          n_strobe = 0, first_strobe = 0, last_strobe = 0, addr_bad = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_pc          (pc),
        .o_cpu_rst_n   (cpu_rst_n),
        .o_cpu_run     (cpu_run),
        .o_mem_rd_en   (mem_rd_en),
        .o_mem_addr    (mem_addr),
        .i_mem_rdata   (mem_rdata),
        .o_cycle_count (cycle_count),
        .o_checksum    (checksum),
        .o_busy        (busy),
        .o_done        (done),
        .o_timeout     (timeout)
    );

    // CPU/memory model: run index follows the CPU's own reset/enable; memory has 1-cycle read latency.
    always @(posedge clk) begin
        pcyc <= pcyc + 1;
        if (!cpu_rst_n)   run_idx <= 0;
        else if (cpu_run) run_idx <= run_idx + 1;
        if (log_clr) begin
            n_strobe <= 0;
            addr_bad <= 0;
        end else if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr[5:2]];
            if (mem_addr != 32'(n_strobe * 4)) addr_bad <= addr_bad + 1;
            if (n_strobe == 0) first_strobe <= pcyc;
            last_strobe <= pcyc;
            n_strobe    <= n_strobe + 1;
        end
    end

    always_comb begin
        case (mode)
            0:       pc = (run_idx < 20) ? 32'(run_idx * 4) : 32'h40;
            1:       pc = 32'h100 + 32'(run_idx * 4);
            default: pc = (run_idx < 492) ? 32'h100 + 32'(run_idx * 4) : 32'h2000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_acc = pcyc;
    endtask

    task automatic wait_done(input string tag, output int lat);
        int k;
        k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        lat = pcyc - t_acc;
    endtask

    // Launch a run from IDLE/DONE and check the start-edge clears and the reset pulse length.
    task automatic launch(input int m, input string tag);
        int n;
        mode    = m;
        log_clr = 1'b1;
        pulse_start();
        log_clr = 1'b0;
        chk({tag, "_cnt_clr"}, cycle_count, 32'd0);
        chk({tag, "_sum_clr"}, checksum, 32'd0);
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!cpu_rst_n && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_rst_low"}, 32'(n), 32'd4);
    endtask

    task automatic finish_checks(input string tag, input int lat, input int exp_lat,
                                 input logic [31:0] exp_cnt, input logic exp_tmo,
                                 input logic [31:0] exp_sum);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_count"}, cycle_count, exp_cnt);
        chk({tag, "_timeout"}, 32'(timeout), 32'(exp_tmo));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        chk({tag, "_checksum"}, checksum, exp_sum);
        chk({tag, "_rd_en_off"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_addr_hold"}, mem_addr, 32'h3C);
        chk({tag, "_strobes"}, 32'(n_strobe), 32'd16);
        chk({tag, "_addr_bad"}, 32'(addr_bad), 32'd0);
        chk({tag, "_strobe_span"}, 32'(last_strobe - first_strobe), 32'd15);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_count"}, cycle_count, 32'd0);
        chk({tag, "_sum"}, checksum, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        int lat;
        int k;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Halt on PC stuck at 0x40 from run cycle 20; words 1..16 summed.
        launch(0, "halt");
        wait_done("halt", lat);
        finish_checks("halt", lat, 49, 32'd28, 1'b0, 32'd136);

        // PC never settles: budget exhausted.
        launch(1, "tmo");
        wait_done("tmo", lat);
        finish_checks("tmo", lat, 521, 32'd500, 1'b1, 32'd136);

        // Halt and timeout in the same cycle: halt wins.
        launch(2, "tie");
        wait_done("tie", lat);
        finish_checks("tie", lat, 521, 32'd500, 1'b0, 32'd136);

        // All-ones window wraps the checksum.
        for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF;
        launch(0, "wrap");
        wait_done("wrap", lat);
        finish_checks("wrap", lat, 49, 32'd28, 1'b0, 32'hFFFF_FFF0);
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);

        // Async reset in the middle of RUN, then a clean run.
        launch(1, "abort");
        k = 0;
        while (run_idx < 37 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reached_run37", 32'(run_idx), 32'd37);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("abort_rst");
        rst_n = 1'b1;
        @(negedge clk);
        launch(0, "rerun");
        wait_done("rerun", lat);
        finish_checks("rerun", lat, 49, 32'd28, 1'b0, 32'd136);

        // Start pulses while busy must be ignored in every busy state.
        mode    = 0;
        log_clr = 1'b1;
        pulse_start();
        log_clr = 1'b0;
        k = t_acc;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_acc = k;
        lat = 0;
        while (run_idx < 10 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!mem_rd_en && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", lat);
        finish_checks("ign", lat, 49, 32'd28, 1'b0, 32'd136);

        // Frozen in DONE.
        repeat (5) @(negedge clk);
        chk("frozen_done", 32'(done), 32'd1);
        chk("frozen_count", cycle_count, 32'd28);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
